// File: rtl/neuron_cfg_pkg.sv
// neuron_cfg_pkg: shared types and helpers for the neuron configuration loader.
//   cfg_state_t : loader FSM states
//   SHIFT_BITS  : width of the neuron decay-shift field
//   cfg_bytes() : number of stream bytes that carry one packed configuration word
package neuron_cfg_pkg;

    localparam int unsigned SHIFT_BITS = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    // Bytes needed for {bias, shift, weights}, rounded up to whole bytes.
    function automatic int unsigned cfg_bytes(input int unsigned synapses,
                                              input int unsigned membrane_bits);
        return (synapses + SHIFT_BITS + membrane_bits + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/cfg_byte_assembler.sv
// cfg_byte_assembler: byte counter plus shadow register for one configuration frame.
// Optional macro: NEURON_CFG_CHECKSUM_EN adds the running XOR of the data bytes.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart frame (counter, shadow and XOR cleared)
//   write       : store data_in at the current byte index and advance
//   data_in     : incoming byte
//   shadow      : assembled configuration word (little-endian byte order)
//   xor_sum     : XOR of all bytes written since clear (checksum build only)
//   last_byte   : the next write fills the final byte of the frame
module cfg_byte_assembler
    import neuron_cfg_pkg::*;
#(
    parameter int unsigned CONFIG_BITS = 42,
    parameter int unsigned BYTES       = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   write,
    input  logic [7:0]             data_in,
    output logic [CONFIG_BITS-1:0] shadow,
`ifdef NEURON_CFG_CHECKSUM_EN
    output logic [7:0]             xor_sum,
`endif
    output logic                   last_byte
);

    localparam int unsigned CNT_BITS = (BYTES > 1) ? $clog2(BYTES + 1) : 1;

    logic [CNT_BITS-1:0] count;

    assign last_byte = (count == CNT_BITS'(BYTES - 1));

    // Byte-indexed shadow write; bits beyond CONFIG_BITS in the last byte are dropped.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count  <= '0;
            shadow <= '0;
        end else if (write) begin
            for (int unsigned b = 0; b < CONFIG_BITS; b++) begin
                if (count == CNT_BITS'(b / 8)) begin
                    shadow[b] <= data_in[b % 8];
                end
            end
            count <= count + CNT_BITS'(1);
        end
    end

`ifdef NEURON_CFG_CHECKSUM_EN
    // Running XOR covers all 8 bits of every data byte, including unused high bits.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            xor_sum <= 8'h00;
        end else if (write) begin
            xor_sum <= xor_sum ^ data_in;
        end
    end
`endif

endmodule

// File: rtl/neuron_config_loader.sv
// neuron_config_loader: byte-serial configuration front end for neuron_pwm.
// Collects a {bias, shift, weights} frame into a shadow register and commits it
// atomically to the active outputs. Optional macro: NEURON_CFG_CHECKSUM_EN adds a
// trailing XOR checksum byte and the CHECK state.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : begin a new frame (aborts any frame in progress)
//   data_in, data_valid  : byte stream input
//   data_ready           : byte accepted this cycle when data_valid is high
//   hold                 : inhibit commit while high
//   weights, shift, bias : active configuration driving the neuron
//   busy                 : loader not idle
//   committed            : one-cycle pulse, new configuration visible
//   error                : one-cycle pulse, checksum mismatch
module neuron_config_loader
    import neuron_cfg_pkg::*;
#(
    parameter int unsigned SYNAPSES      = 32,
    parameter int unsigned MEMBRANE_BITS = $clog2(SYNAPSES) + 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [7:0]                      data_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    input  logic                            hold,
    output logic [SYNAPSES-1:0]             weights,
    output logic [SHIFT_BITS-1:0]           shift,
    output logic signed [MEMBRANE_BITS-1:0] bias,
    output logic                            busy,
    output logic                            committed,
    output logic                            error
);

    localparam int unsigned CONFIG_BITS = SYNAPSES + SHIFT_BITS + MEMBRANE_BITS;
    localparam int unsigned BYTES       = cfg_bytes(SYNAPSES, MEMBRANE_BITS);

    cfg_state_t             state_q;
    cfg_state_t             state_d;
    logic                   accept;
    logic                   write_byte;
    logic                   commit_now;
    logic                   last_byte;
    logic [CONFIG_BITS-1:0] shadow;
`ifdef NEURON_CFG_CHECKSUM_EN
    logic [7:0]             xor_sum;
    logic                   cks_bad;
`endif

    // start blocks the handshake so a byte in the restart cycle is never taken.
    assign data_ready = ((state_q == LOAD) || (state_q == CHECK)) && !start;
    assign accept     = data_valid && data_ready;

    cfg_byte_assembler #(
        .CONFIG_BITS (CONFIG_BITS),
        .BYTES       (BYTES)
    ) u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .write     (write_byte),
        .data_in   (data_in),
        .shadow    (shadow),
`ifdef NEURON_CFG_CHECKSUM_EN
        .xor_sum   (xor_sum),
`endif
        .last_byte (last_byte)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; start overrides every state.
    always_comb begin
        state_d    = state_q;
        write_byte = 1'b0;
        commit_now = 1'b0;
`ifdef NEURON_CFG_CHECKSUM_EN
        cks_bad    = 1'b0;
`endif
        if (start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LOAD: begin
                    if (accept) begin
                        write_byte = 1'b1;
                        if (last_byte) begin
`ifdef NEURON_CFG_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = COMMIT;
`endif
                        end
                    end
                end
`ifdef NEURON_CFG_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (data_in == xor_sum) begin
                            state_d = COMMIT;
                        end else begin
                            cks_bad = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
`endif
                COMMIT: begin
                    if (!hold) begin
                        commit_now = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Active configuration and status flags; configuration changes only on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            weights   <= '0;
            shift     <= '0;
            bias      <= '0;
            busy      <= 1'b0;
            committed <= 1'b0;
        end else begin
            busy      <= (state_d != IDLE);
            committed <= commit_now;
            if (commit_now) begin
                weights <= shadow[SYNAPSES-1:0];
                shift   <= shadow[SYNAPSES +: SHIFT_BITS];
                bias    <= shadow[SYNAPSES+SHIFT_BITS +: MEMBRANE_BITS];
            end
        end
    end

`ifdef NEURON_CFG_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            error <= 1'b0;
        end else begin
            error <= cks_bad;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_config_loader.sv
// tb_neuron_config_loader: self-checking bench for neuron_config_loader.
// A frame-level model (packed word sliced into weights/shift/bias, expected
// status flags) is compared against the DUT on every falling edge, plus literal
// expectations after each frame. Works with or without NEURON_CFG_CHECKSUM_EN.
module tb_neuron_config_loader;

    localparam int unsigned SYN = 32;
    localparam int unsigned MB  = 7;
    localparam int unsigned NB  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          data_ready;
    logic          hold;
    logic [SYN-1:0] weights;
    logic [2:0]    shift;
    logic [MB-1:0] bias;
    logic          busy;
    logic          committed;
    logic          error;

    neuron_config_loader #(
        .SYNAPSES      (SYN),
        .MEMBRANE_BITS (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .hold       (hold),
        .weights    (weights),
        .shift      (shift),
        .bias       (bias),
        .busy       (busy),
        .committed  (committed),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected DUT view.
    logic [SYN-1:0] exp_weights = '0;
    logic [2:0]     exp_shift   = '0;
    logic [MB-1:0]  exp_bias    = '0;
    logic           exp_committed = 1'b0;
    logic           exp_error     = 1'b0;
    logic           exp_busy      = 1'b0;
    logic           exp_rx        = 1'b0;   // loader is taking data or checksum bytes
    logic           mon_en        = 1'b0;
    logic           lat_en        = 1'b0;

    int ncyc    = 0;
    int hs_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        ncyc++;
        if (mon_en) begin
            check("weights",    64'(weights),    64'(exp_weights));
            check("shift",      64'(shift),      64'(exp_shift));
            check("bias",       64'(bias),       64'(exp_bias));
            check("committed",  64'(committed),  64'(exp_committed));
            check("error",      64'(error),      64'(exp_error));
            check("busy",       64'(busy),       64'(exp_busy));
            check("data_ready", 64'(data_ready), 64'(exp_rx && !start));
            if (data_valid && data_ready) hs_seen = ncyc;
            // Edges from the last handshake edge to the commit edge, inclusive.
            if (lat_en && committed) begin
                check("commit_latency_edges", 64'(ncyc - hs_seen), 64'd2);
                lat_en = 1'b0;
            end
        end
    end

    // Sends one full frame; fw holds byte k in bits [8k+7:8k].
    task automatic run_frame(input logic [8*NB-1:0] fw, input int gap, input int hold_cyc,
                             input logic [7:0] cks_flip, input bit junk_on_start);
        logic [7:0] cks;
        cks        = 8'h00;
        start      = 1'b1;
        data_valid = junk_on_start;
        data_in    = 8'hA5;
        tick();
        start      = 1'b0;
        data_valid = 1'b0;
        exp_busy   = 1'b1;
        exp_rx     = 1'b1;
        for (int unsigned k = 0; k < NB; k++) begin
            repeat (gap) tick();
            data_valid = 1'b1;
            data_in    = fw[8*k +: 8];
            cks        = cks ^ fw[8*k +: 8];
            hold       = (hold_cyc > 0);
            tick();
            data_valid = 1'b0;
        end
`ifdef NEURON_CFG_CHECKSUM_EN
        repeat (gap) tick();
        data_valid = 1'b1;
        data_in    = cks ^ cks_flip;
        tick();
        data_valid = 1'b0;
        if (cks_flip != 8'h00) begin
            exp_error = 1'b1;
            exp_busy  = 1'b0;
            exp_rx    = 1'b0;
            hold      = 1'b0;
            tick();
            exp_error = 1'b0;
            return;
        end
`endif
        exp_rx = 1'b0;
        repeat (hold_cyc) tick();
        hold = 1'b0;
        tick();
        exp_weights   = fw[SYN-1:0];
        exp_shift     = fw[SYN +: 3];
        exp_bias      = fw[SYN+3 +: MB];
        exp_committed = 1'b1;
        exp_busy      = 1'b0;
        tick();
        exp_committed = 1'b0;
    endtask

    task automatic begin_partial(input int nbytes);
        start = 1'b1;
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_rx   = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            data_valid = 1'b1;
            data_in    = 8'(8'h11 * (k + 1));
            tick();
            data_valid = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        hold       = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_weights", 64'(weights), 64'd0);
        check("rst_bias",    64'(bias),    64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        reset = 1'b0;
        tick();

        // Bytes while idle are ignored.
        data_valid = 1'b1;
        data_in    = 8'h99;
        tick();
        tick();
        data_valid = 1'b0;

        // Default frame, back-to-back bytes.
        lat_en = 1'b1;
        run_frame(48'h002B_1234_5678, 0, 0, 8'h00, 1'b0);
        check("f1_weights", 64'(weights), 64'h12345678);
        check("f1_shift",   64'(shift),   64'd3);
        check("f1_bias",    64'(bias),    64'd5);
        check("f1_latency_seen", 64'(lat_en), 64'd0);

        // Negative bias, with valid gaps.
        run_frame(48'h03FA_DEAD_BEEF, 2, 0, 8'h00, 1'b0);
        check("f2_weights", 64'(weights), 64'hDEADBEEF);
        check("f2_shift",   64'(shift),   64'd2);
        check("f2_bias",    64'(bias),    64'h7F);

        // Abort after 3 bytes; restart cycle also presents a byte that must be dropped.
        begin_partial(3);
        run_frame(48'h0053_CAFE_F00D, 1, 0, 8'h00, 1'b1);
        check("f3_weights", 64'(weights), 64'hCAFEF00D);
        check("f3_shift",   64'(shift),   64'd3);
        check("f3_bias",    64'(bias),    64'h0A);

        // Hold in COMMIT for 10 cycles.
        run_frame(48'h0109_0F0F_0F0F, 0, 10, 8'h00, 1'b0);
        check("f4_weights", 64'(weights), 64'h0F0F0F0F);
        check("f4_shift",   64'(shift),   64'd1);
        check("f4_bias",    64'(bias),    64'h21);

`ifdef NEURON_CFG_CHECKSUM_EN
        // Checksum 0x24 instead of 0x23: discarded.
        run_frame(48'h002B_1234_5678, 0, 0, 8'h07, 1'b0);
        check("cks_bad_weights", 64'(weights), 64'h0F0F0F0F);
        run_frame(48'h002B_1234_5678, 0, 0, 8'h00, 1'b0);
        check("cks_ok_weights", 64'(weights), 64'h12345678);
`endif

        // Reset mid-frame after 4 bytes.
        begin_partial(4);
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h55;
        tick();
        reset       = 1'b0;
        exp_weights = '0;
        exp_shift   = '0;
        exp_bias    = '0;
        exp_busy    = 1'b0;
        exp_rx      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_in = 8'(8'h60 + k);
            tick();
        end
        data_valid = 1'b0;
        check("rst_mid_weights", 64'(weights), 64'd0);
        check("rst_mid_busy",    64'(busy),    64'd0);
        run_frame(48'h0012_8765_4321, 0, 0, 8'h00, 1'b0);
        check("f5_weights", 64'(weights), 64'h87654321);
        check("f5_shift",   64'(shift),   64'd2);
        check("f5_bias",    64'(bias),    64'd2);

        tick();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
